// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: operand width and FSM states.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and report the quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next,
  output logic             qbit
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  // rem stays below dvs, so whenever the subtraction is taken the true
  // difference fits in WIDTH bits and a modular subtract is exact.
  always_comb begin
    rem_sh   = {rem, dvd[WIDTH-1]};
    qbit     = (rem_sh >= {1'b0, dvs});
    diff     = rem_sh[WIDTH-1:0] - dvs;
    rem_next = qbit ? diff : rem_sh[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative signed restoring divider for the DIV instruction: one quotient bit
// per cycle on magnitudes, signs restored in a final DONE cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] LODiv,
  output logic [WIDTH-1:0] HIDiv,
  output logic             DivOut,
  output logic             divZero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state, next_state;
  logic             ctrl_q;
  logic             start;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd, dvs, q;
  logic [WIDTH-1:0] rem_nx, dvd_nx;
  logic             qbit;
  logic             sign_q, sign_r;
  logic [WIDTH-1:0] abs_a, abs_b;

  // Only a rising edge of DivCtrl seen while idle starts work; ctrl_q resets
  // high so a request held through reset is not mistaken for a new one.
  assign start = DivCtrl & ~ctrl_q & (state == IDLE);
  assign abs_a = A[WIDTH-1] ? -A : A;
  assign abs_b = B[WIDTH-1] ? -B : B;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd      (dvd),
    .dvs      (dvs),
    .rem_next (rem_nx),
    .dvd_next (dvd_nx),
    .qbit     (qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && (B != '0)) next_state = RUN;
      RUN:     if (cnt == CW'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= 1'b1;
      cnt     <= '0;
      rem     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      q       <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      LODiv   <= '0;
      HIDiv   <= '0;
      DivOut  <= 1'b0;
      divZero <= 1'b0;
    end else begin
      ctrl_q  <= DivCtrl;
      DivOut  <= 1'b0;
      divZero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (B == '0) begin
              divZero <= 1'b1;
            end else begin
              dvd    <= abs_a;
              dvs    <= abs_b;
              rem    <= '0;
              q      <= '0;
              sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
              sign_r <= A[WIDTH-1];
              cnt    <= CW'(WIDTH);
            end
          end
        end
        RUN: begin
          rem <= rem_nx;
          dvd <= dvd_nx;
          q   <= {q[WIDTH-2:0], qbit};
          cnt <= cnt - CW'(1);
        end
        // INT_MIN / -1 falls out naturally: the magnitude quotient is
        // 0x80000000 and sign_q is 0, so it is returned unchanged.
        DONE: begin
          LODiv  <= sign_q ? -q : q;
          HIDiv  <= sign_r ? -rem : rem;
          DivOut <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
